// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one synchronous ROM read port between two requesters
module rom_arbiter #(
    parameter int MEM_ADDR  = 6,
    parameter int MEM_EXTRA = 4,
    localparam int DW       = (2 ** MEM_EXTRA) * 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_req,
    input  logic                b_req,
    input  logic [MEM_ADDR:0]   a_addr,
    input  logic [MEM_ADDR:0]   b_addr,
    input  logic [MEM_EXTRA-1:0] a_extra,
    input  logic [MEM_EXTRA-1:0] b_extra,
    input  logic [MEM_ADDR:0]   a_lower,
    input  logic [MEM_ADDR:0]   a_upper,
    input  logic [MEM_ADDR:0]   b_lower,
    input  logic [MEM_ADDR:0]   b_upper,
    output logic                a_gnt,
    output logic                b_gnt,
    output logic                a_ack,
    output logic                b_ack,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_error,
    output logic [MEM_ADDR:0]   mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [MEM_ADDR:0]   mem_lower,
    output logic [MEM_ADDR:0]   mem_upper,
    input  logic [DW-1:0]       mem_data,
    input  logic                mem_error
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    // Requester encoding for owner/last: 0 = A, 1 = B.
    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic                 gnt_a_q, gnt_a_d;
    logic                 gnt_b_q, gnt_b_d;
    logic [DW-1:0]        rsp_data_q, rsp_data_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [MEM_ADDR:0]    mem_addr_q, mem_addr_d;
    logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
    logic [MEM_ADDR:0]    mem_lower_q, mem_lower_d;
    logic [MEM_ADDR:0]    mem_upper_q, mem_upper_d;

    logic capture;
    logic arb_last;
    logic req_a_eff;
    logic req_b_eff;
    logic win_any;
    logic win_b;
    logic cap_gnt_a;
    logic cap_gnt_b;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        mem_lower_d = mem_lower_q;
        mem_upper_d = mem_upper_q;
        cap_gnt_a   = 1'b0;
        cap_gnt_b   = 1'b0;

        // During CAPTURE the owner is being acked, so its req is masked and
        // the arbitration already sees last = owner.
        capture   = (state_q == CAPTURE);
        arb_last  = capture ? owner_q : last_q;
        req_a_eff = a_req & ~(capture & ~owner_q);
        req_b_eff = b_req & ~(capture & owner_q);
        win_any   = req_a_eff | req_b_eff;
        win_b     = req_b_eff & (~req_a_eff | ~arb_last);

        if ((state_q == IDLE || capture) && win_any) begin
            owner_d     = win_b;
            mem_addr_d  = win_b ? b_addr  : a_addr;
            mem_extra_d = win_b ? b_extra : a_extra;
            mem_lower_d = win_b ? b_lower : a_lower;
            mem_upper_d = win_b ? b_upper : a_upper;
        end

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_a_d = ~win_b;
                    gnt_b_d = win_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d  = mem_data;
                rsp_error_d = mem_error;
                last_d      = owner_q;
                if (win_any) begin
                    cap_gnt_a = ~win_b;
                    cap_gnt_b = win_b;
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            mem_lower_q <= '0;
            mem_upper_q <= '1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            mem_lower_q <= mem_lower_d;
            mem_upper_q <= mem_upper_d;
        end
    end

    // ROM data is already registered by the ROM, so it is forwarded in the
    // ack cycle and held from the capture register afterwards.
    assign a_gnt     = gnt_a_q | cap_gnt_a;
    assign b_gnt     = gnt_b_q | cap_gnt_b;
    assign a_ack     = capture & ~owner_q;
    assign b_ack     = capture & owner_q;
    assign rsp_data  = capture ? mem_data : rsp_data_q;
    assign rsp_error = capture ? mem_error : rsp_error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_extra = mem_extra_q;
    assign mem_lower = mem_lower_q;
    assign mem_upper = mem_upper_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed table-driven bench for rom_arbiter with a synchronous ROM model
module tb_rom_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         a_req = 1'b0, b_req = 1'b0;
    logic [6:0]   a_addr = '0, b_addr = '0;
    logic [3:0]   a_extra = '0, b_extra = '0;
    logic [6:0]   a_lower = '0, a_upper = 7'h7f, b_lower = '0, b_upper = 7'h7f;
    logic         a_gnt, b_gnt, a_ack, b_ack;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic [6:0]   mem_addr, mem_lower, mem_upper;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data = '0;
    logic         mem_error = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    rom_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_extra(a_extra), .b_extra(b_extra),
        .a_lower(a_lower), .a_upper(a_upper),
        .b_lower(b_lower), .b_upper(b_upper),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack),
        .rsp_data(rsp_data), .rsp_error(rsp_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower(mem_lower), .mem_upper(mem_upper),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word(a) = 0x0102030405060708 with (a ^ 33) in bits 70:64.
    function automatic logic [127:0] rom_word(input logic [6:0] a);
        logic [127:0] w;
        w = 128'h0102030405060708;
        w[70:64] = a ^ 7'd33;
        return w;
    endfunction

    always @(posedge clk) begin
        mem_data  <= rom_word(mem_addr);
        mem_error <= (mem_addr < mem_lower) || (mem_addr > mem_upper);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] pulses();
        return {a_gnt, b_gnt, a_ack, b_ack};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit           is_b;
        logic [6:0]   addr;
        logic [3:0]   extra;
        logic [6:0]   lo;
        logic [6:0]   hi;
        logic [127:0] data;
        logic         err;
    } vec_t;

    vec_t vecs[5];
    logic [3:0] acc;

    initial begin
        vecs[0] = '{1'b0, 7'd33,  4'd3, 7'd0,  7'd127, 128'h0102030405060708,    1'b0};
        vecs[1] = '{1'b1, 7'd70,  4'd2, 7'd0,  7'd63,  128'h67_0102030405060708, 1'b1};
        vecs[2] = '{1'b0, 7'd127, 4'd1, 7'd0,  7'd127, 128'h5E_0102030405060708, 1'b0};
        vecs[3] = '{1'b1, 7'd0,   4'd0, 7'd0,  7'd127, 128'h21_0102030405060708, 1'b0};
        vecs[4] = '{1'b0, 7'd5,   4'd3, 7'd10, 7'd20,  128'h24_0102030405060708, 1'b1};

        #2 reset_n = 1'b0;
        #1;
        chk("reset_pulses", 128'(pulses()), 128'h0);
        chk("reset_rsp", {rsp_error, rsp_data}, '0);
        chk("reset_mem", {mem_addr, mem_extra, mem_lower, mem_upper}, {7'd0, 4'd0, 7'd0, 7'h7f});
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single-requester table, including the out-of-bounds error passthrough.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_b) begin
                b_req = 1'b1; b_addr = vecs[i].addr; b_extra = vecs[i].extra;
                b_lower = vecs[i].lo; b_upper = vecs[i].hi;
            end else begin
                a_req = 1'b1; a_addr = vecs[i].addr; a_extra = vecs[i].extra;
                a_lower = vecs[i].lo; a_upper = vecs[i].hi;
            end
            step();
            chk($sformatf("v%0d_gnt", i), 128'(pulses()), vecs[i].is_b ? 128'h4 : 128'h8);
            chk($sformatf("v%0d_mem", i), {mem_addr, mem_extra, mem_lower, mem_upper},
                {vecs[i].addr, vecs[i].extra, vecs[i].lo, vecs[i].hi});
            step();
            chk($sformatf("v%0d_ack", i), 128'(pulses()), vecs[i].is_b ? 128'h1 : 128'h2);
            chk($sformatf("v%0d_data", i), rsp_data, vecs[i].data);
            chk($sformatf("v%0d_err", i), 128'(rsp_error), 128'(vecs[i].err));
            a_req = 1'b0;
            b_req = 1'b0;
            step();
            chk($sformatf("v%0d_idle_hold", i), {pulses(), rsp_data}, {4'h0, vecs[i].data});
        end

        // Collision right after reset: A first, B granted alongside A's ack.
        do_reset();
        a_addr = 7'd10; b_addr = 7'd20;
        a_lower = 7'd0; a_upper = 7'd127; b_lower = 7'd0; b_upper = 7'd127;
        a_req = 1'b1; b_req = 1'b1;
        step();
        chk("col_gnt_a", {pulses(), mem_addr}, {4'h8, 7'd10});
        step();
        chk("col_ack_a_gnt_b", {pulses(), rsp_data}, {4'h6, 128'h2B_0102030405060708});
        a_req = 1'b0;
        step();
        chk("col_issue_b", {pulses(), mem_addr}, {4'h0, 7'd20});
        step();
        chk("col_ack_b", {pulses(), rsp_data}, {4'h1, 128'h35_0102030405060708});
        b_req = 1'b0;
        step();
        chk("col_idle", 128'(pulses()), 128'h0);

        // Sustained contention: 10 acks alternating A, B with one ack every 2 cycles.
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) begin
                chk("sus_first_gnt", 128'(pulses()), 128'h8);
            end else if (c % 2 == 1) begin
                chk($sformatf("sus_c%0d_quiet", c), 128'(pulses()), 128'h0);
            end else if ((c / 2) % 2 == 1) begin
                chk($sformatf("sus_c%0d_ackA", c), {pulses(), rsp_data}, {4'h6, 128'h2B_0102030405060708});
            end else begin
                chk($sformatf("sus_c%0d_ackB", c), {pulses(), rsp_data}, {4'h9, 128'h35_0102030405060708});
            end
        end
        do_reset();

        // Reset asserted during ISSUE: immediate reset values, no ack afterwards.
        a_addr = 7'd33; a_extra = 4'd3;
        a_req = 1'b1;
        step();
        chk("rst_pre_gnt", 128'(pulses()), 128'h8);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_pulses", 128'(pulses()), 128'h0);
        chk("rst_async_rsp", {rsp_error, rsp_data}, '0);
        chk("rst_async_mem", {mem_addr, mem_extra, mem_lower, mem_upper}, {7'd0, 4'd0, 7'd0, 7'h7f});
        a_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            acc = acc | pulses();
        end
        chk("rst_no_ack", 128'(acc), 128'h0);
        a_addr = 7'd5; a_lower = 7'd0; a_upper = 7'd127;
        a_req = 1'b1;
        step();
        chk("rst_new_gnt", 128'(pulses()), 128'h8);
        step();
        chk("rst_new_ack", {pulses(), rsp_error, rsp_data}, {4'h2, 1'b0, 128'h24_0102030405060708});
        a_req = 1'b0;
        step();

        // Req dropped in the cycle after grant: ack still issued, nothing re-issued.
        a_addr = 7'd127;
        a_req = 1'b1;
        step();
        chk("drop_gnt", 128'(pulses()), 128'h8);
        step();
        a_req = 1'b0;
        #1;
        chk("drop_ack", {pulses(), rsp_data}, {4'h2, 128'h5E_0102030405060708});
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            acc = acc | pulses();
        end
        chk("drop_no_reissue", 128'(acc), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
